// File: rtl/alu_issue_queue.sv
// Collapsing out-of-order issue queue for the single-cycle ALU; oldest ready entry issues first.
// Latency: a ready dispatch issues two edges later. Backpressure: iq_full from registered count only.
module alu_issue_queue #(
    parameter int DEPTH             = 8,
    parameter int PTAG_WIDTH        = 6,
    parameter int ROB_PTR_WIDTH     = 5,
    parameter int DATA_WIDTH_ALU_OP = 4,
    parameter int PC_WIDTH          = 32,
    parameter int WORD_WIDTH        = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,

    input  logic                         disp_valid,
    input  logic [DATA_WIDTH_ALU_OP-1:0] disp_op,
    input  logic [PC_WIDTH-1:0]          disp_pc,
    input  logic [WORD_WIDTH-1:0]        disp_imm,
    input  logic [PTAG_WIDTH-1:0]        disp_rs1_ptag,
    input  logic [PTAG_WIDTH-1:0]        disp_rs2_ptag,
    input  logic                         disp_rs1_ready,
    input  logic                         disp_rs2_ready,
    input  logic [WORD_WIDTH-1:0]        disp_rs1_value,
    input  logic [WORD_WIDTH-1:0]        disp_rs2_value,
    input  logic [PTAG_WIDTH-1:0]        disp_rd_ptag,
    input  logic [ROB_PTR_WIDTH-1:0]     disp_rob_ptr,
    output logic                         iq_full,

    input  logic                         wb0_valid,
    input  logic [PTAG_WIDTH-1:0]        wb0_ptag,
    input  logic [WORD_WIDTH-1:0]        wb0_value,
    input  logic                         wb1_valid,
    input  logic [PTAG_WIDTH-1:0]        wb1_ptag,
    input  logic [WORD_WIDTH-1:0]        wb1_value,

    output logic                         alu_issue_en,
    output logic [DATA_WIDTH_ALU_OP-1:0] alu_issue_queue_op,
    output logic [PC_WIDTH-1:0]          alu_issue_queue_pc,
    output logic [WORD_WIDTH-1:0]        alu_issue_queue_imm,
    output logic [WORD_WIDTH-1:0]        alu_issue_queue_rs1_value,
    output logic [WORD_WIDTH-1:0]        alu_issue_queue_rs2_value,
    output logic [PTAG_WIDTH-1:0]        alu_issue_queue_rd_ptag,
    output logic [ROB_PTR_WIDTH-1:0]     alu_issue_queue_rob_ptr
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic                         valid;
        logic [DATA_WIDTH_ALU_OP-1:0] op;
        logic [PC_WIDTH-1:0]          pc;
        logic [WORD_WIDTH-1:0]        imm;
        logic [PTAG_WIDTH-1:0]        rs1_ptag;
        logic                         rs1_ready;
        logic [WORD_WIDTH-1:0]        rs1_value;
        logic [PTAG_WIDTH-1:0]        rs2_ptag;
        logic                         rs2_ready;
        logic [WORD_WIDTH-1:0]        rs2_value;
        logic [PTAG_WIDTH-1:0]        rd_ptag;
        logic [ROB_PTR_WIDTH-1:0]     rob_ptr;
    } entry_t;

    entry_t           q   [DEPTH];
    entry_t           upd [DEPTH+1];
    entry_t           nxt [DEPTH];
    entry_t           disp_e;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] wr_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             issue;
    logic             accept;

    // Capture a broadcast into any not-ready source; port 0 takes priority.
    function automatic entry_t wake(input entry_t e);
        entry_t r;
        r = e;
        if (!r.rs1_ready) begin
            if (wb0_valid && (wb0_ptag == r.rs1_ptag)) begin
                r.rs1_ready = 1'b1;
                r.rs1_value = wb0_value;
            end else if (wb1_valid && (wb1_ptag == r.rs1_ptag)) begin
                r.rs1_ready = 1'b1;
                r.rs1_value = wb1_value;
            end
        end
        if (!r.rs2_ready) begin
            if (wb0_valid && (wb0_ptag == r.rs2_ptag)) begin
                r.rs2_ready = 1'b1;
                r.rs2_value = wb0_value;
            end else if (wb1_valid && (wb1_ptag == r.rs2_ptag)) begin
                r.rs2_ready = 1'b1;
                r.rs2_value = wb1_value;
            end
        end
        return r;
    endfunction

    assign iq_full = (count == CNT_W'(DEPTH));
    assign accept  = disp_valid && !iq_full && !flush;
    assign issue   = sel_found && !flush;
    assign wr_idx  = count - CNT_W'(issue);

    // Selection looks only at registered ready bits, so a wakeup costs one cycle.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (q[i].valid && q[i].rs1_ready && q[i].rs2_ready) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        disp_e           = '0;
        disp_e.valid     = 1'b1;
        disp_e.op        = disp_op;
        disp_e.pc        = disp_pc;
        disp_e.imm       = disp_imm;
        disp_e.rs1_ptag  = disp_rs1_ptag;
        disp_e.rs1_ready = disp_rs1_ready;
        disp_e.rs1_value = disp_rs1_value;
        disp_e.rs2_ptag  = disp_rs2_ptag;
        disp_e.rs2_ready = disp_rs2_ready;
        disp_e.rs2_value = disp_rs2_value;
        disp_e.rd_ptag   = disp_rd_ptag;
        disp_e.rob_ptr   = disp_rob_ptr;
        disp_e           = wake(disp_e);
    end

    // upd[DEPTH] is an empty sentinel shifted into the top slot on issue.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            upd[i] = q[i].valid ? wake(q[i]) : q[i];
        end
        upd[DEPTH] = '0;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = (issue && (i >= int'(sel_idx))) ? upd[i+1] : upd[i];
            if (accept && (wr_idx == CNT_W'(i))) begin
                nxt[i] = disp_e;
            end
        end
    end

    assign count_nxt = count - CNT_W'(issue) + CNT_W'(accept);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i].valid <= 1'b0;
            end
        end else begin
            count <= count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                q[i] <= nxt[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_issue_en              <= 1'b0;
            alu_issue_queue_op        <= '0;
            alu_issue_queue_pc        <= '0;
            alu_issue_queue_imm       <= '0;
            alu_issue_queue_rs1_value <= '0;
            alu_issue_queue_rs2_value <= '0;
            alu_issue_queue_rd_ptag   <= '0;
            alu_issue_queue_rob_ptr   <= '0;
        end else begin
            alu_issue_en <= issue;
            if (issue) begin
                alu_issue_queue_op        <= q[sel_idx].op;
                alu_issue_queue_pc        <= q[sel_idx].pc;
                alu_issue_queue_imm       <= q[sel_idx].imm;
                alu_issue_queue_rs1_value <= q[sel_idx].rs1_value;
                alu_issue_queue_rs2_value <= q[sel_idx].rs2_value;
                alu_issue_queue_rd_ptag   <= q[sel_idx].rd_ptag;
                alu_issue_queue_rob_ptr   <= q[sel_idx].rob_ptr;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: dispatch, wakeup, bypass, ordering, full, flush, reset.
module tb_alu_issue_queue;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        disp_valid;
    logic [3:0]  disp_op;
    logic [31:0] disp_pc, disp_imm;
    logic [5:0]  disp_rs1_ptag, disp_rs2_ptag, disp_rd_ptag;
    logic        disp_rs1_ready, disp_rs2_ready;
    logic [31:0] disp_rs1_value, disp_rs2_value;
    logic [4:0]  disp_rob_ptr;
    logic        iq_full;
    logic        wb0_valid, wb1_valid;
    logic [5:0]  wb0_ptag, wb1_ptag;
    logic [31:0] wb0_value, wb1_value;
    logic        alu_issue_en;
    logic [3:0]  alu_issue_queue_op;
    logic [31:0] alu_issue_queue_pc, alu_issue_queue_imm;
    logic [31:0] alu_issue_queue_rs1_value, alu_issue_queue_rs2_value;
    logic [5:0]  alu_issue_queue_rd_ptag;
    logic [4:0]  alu_issue_queue_rob_ptr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_pc(disp_pc), .disp_imm(disp_imm),
        .disp_rs1_ptag(disp_rs1_ptag), .disp_rs2_ptag(disp_rs2_ptag),
        .disp_rs1_ready(disp_rs1_ready), .disp_rs2_ready(disp_rs2_ready),
        .disp_rs1_value(disp_rs1_value), .disp_rs2_value(disp_rs2_value),
        .disp_rd_ptag(disp_rd_ptag), .disp_rob_ptr(disp_rob_ptr), .iq_full(iq_full),
        .wb0_valid(wb0_valid), .wb0_ptag(wb0_ptag), .wb0_value(wb0_value),
        .wb1_valid(wb1_valid), .wb1_ptag(wb1_ptag), .wb1_value(wb1_value),
        .alu_issue_en(alu_issue_en), .alu_issue_queue_op(alu_issue_queue_op),
        .alu_issue_queue_pc(alu_issue_queue_pc), .alu_issue_queue_imm(alu_issue_queue_imm),
        .alu_issue_queue_rs1_value(alu_issue_queue_rs1_value),
        .alu_issue_queue_rs2_value(alu_issue_queue_rs2_value),
        .alu_issue_queue_rd_ptag(alu_issue_queue_rd_ptag),
        .alu_issue_queue_rob_ptr(alu_issue_queue_rob_ptr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        wb0_valid  = 1'b0;
        wb1_valid  = 1'b0;
    endtask

    task automatic dispatch(input logic [3:0] op, input logic [31:0] imm,
                            input logic r1_rdy, input logic [5:0] r1_tag, input logic [31:0] r1_val,
                            input logic r2_rdy, input logic [5:0] r2_tag, input logic [31:0] r2_val,
                            input logic [5:0] rd, input logic [4:0] rob);
        disp_valid     = 1'b1;
        disp_op        = op;
        disp_pc        = 32'h1000 + imm;
        disp_imm       = imm;
        disp_rs1_ready = r1_rdy;
        disp_rs1_ptag  = r1_tag;
        disp_rs1_value = r1_val;
        disp_rs2_ready = r2_rdy;
        disp_rs2_ptag  = r2_tag;
        disp_rs2_value = r2_val;
        disp_rd_ptag   = rd;
        disp_rob_ptr   = rob;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        disp_op = '0; disp_pc = '0; disp_imm = '0;
        disp_rs1_ptag = '0; disp_rs2_ptag = '0; disp_rd_ptag = '0;
        disp_rs1_ready = 1'b0; disp_rs2_ready = 1'b0;
        disp_rs1_value = '0; disp_rs2_value = '0; disp_rob_ptr = '0;
        wb0_ptag = '0; wb1_ptag = '0; wb0_value = '0; wb1_value = '0;
        idle();
        #2;
        check("reset_en", alu_issue_en, 0);
        check("reset_full", iq_full, 0);
        check("reset_count", dut.count, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Ready dispatch
        dispatch(4'd1, 32'd5, 1'b1, 6'd1, 32'd10, 1'b1, 6'd0, 32'd0, 6'd2, 5'd1);
        step(); idle();
        check("ready_t1_en", alu_issue_en, 0);
        check("ready_t1_count", dut.count, 1);
        step();
        check("ready_en", alu_issue_en, 1);
        check("ready_imm", alu_issue_queue_imm, 5);
        check("ready_rs1", alu_issue_queue_rs1_value, 10);
        check("ready_op", alu_issue_queue_op, 1);
        check("ready_pc", alu_issue_queue_pc, 32'h1005);
        check("ready_rd", alu_issue_queue_rd_ptag, 2);
        check("ready_rob", alu_issue_queue_rob_ptr, 1);
        check("ready_count0", dut.count, 0);
        step();
        check("ready_pulse", alu_issue_en, 0);
        check("idle_hold_imm", alu_issue_queue_imm, 5);

        // Wakeup through wb1
        dispatch(4'd2, 32'd0, 1'b1, 6'd1, 32'd3, 1'b0, 6'd7, 32'd0, 6'd3, 5'd2);
        step(); idle();
        step();
        check("wait_en", alu_issue_en, 0);
        wb1_valid = 1'b1; wb1_ptag = 6'd7; wb1_value = 32'd4;
        step(); idle();
        check("wake_same_cycle_en", alu_issue_en, 0);
        step();
        check("wake_en", alu_issue_en, 1);
        check("wake_rs2", alu_issue_queue_rs2_value, 4);
        check("wake_rs1", alu_issue_queue_rs1_value, 3);
        check("wake_rob", alu_issue_queue_rob_ptr, 2);

        // Dispatch bypass, both ports matching: port 0 value wins
        dispatch(4'd3, 32'd0, 1'b1, 6'd1, 32'd1, 1'b0, 6'd9, 32'd0, 6'd4, 5'd3);
        wb0_valid = 1'b1; wb0_ptag = 6'd9; wb0_value = 32'h55;
        wb1_valid = 1'b1; wb1_ptag = 6'd9; wb1_value = 32'h66;
        step(); idle();
        check("bypass_captured", dut.q[0].rs2_ready, 1);
        step();
        check("bypass_en", alu_issue_en, 1);
        check("bypass_rs2", alu_issue_queue_rs2_value, 32'h55);

        // Wakeup with both ports matching on a queued entry
        dispatch(4'd4, 32'd0, 1'b0, 6'd30, 32'd0, 1'b1, 6'd0, 32'd1, 6'd5, 5'd4);
        step(); idle();
        wb0_valid = 1'b1; wb0_ptag = 6'd30; wb0_value = 32'hAA;
        wb1_valid = 1'b1; wb1_ptag = 6'd30; wb1_value = 32'hBB;
        step(); idle();
        step();
        check("prio_en", alu_issue_en, 1);
        check("prio_rs1", alu_issue_queue_rs1_value, 32'hAA);

        // Oldest-first select: wake C and A together
        dispatch(4'd5, 32'd0, 1'b0, 6'd10, 32'd0, 1'b1, 6'd0, 32'd0, 6'd6, 5'd5);
        step();
        dispatch(4'd5, 32'd0, 1'b0, 6'd11, 32'd0, 1'b1, 6'd0, 32'd0, 6'd7, 5'd6);
        step();
        dispatch(4'd5, 32'd0, 1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'd0, 6'd8, 5'd7);
        step(); idle();
        check("abc_count", dut.count, 3);
        wb0_valid = 1'b1; wb0_ptag = 6'd12; wb0_value = 32'hC;
        wb1_valid = 1'b1; wb1_ptag = 6'd10; wb1_value = 32'hA;
        step(); idle();
        check("abc_wake_en", alu_issue_en, 0);
        step();
        check("first_en", alu_issue_en, 1);
        check("first_rob_a", alu_issue_queue_rob_ptr, 5);
        check("first_rs1", alu_issue_queue_rs1_value, 32'hA);
        step();
        check("second_en", alu_issue_en, 1);
        check("second_rob_c", alu_issue_queue_rob_ptr, 7);
        check("second_rs1", alu_issue_queue_rs1_value, 32'hC);
        check("b_remains", dut.count, 1);
        check("b_at_head", dut.q[0].rob_ptr, 6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("abc_flush_count", dut.count, 0);

        // Full back-pressure
        for (int i = 0; i < 8; i++) begin
            dispatch(4'd6, 32'd0, 1'b0, 6'(20 + i), 32'd0, 1'b1, 6'd0, 32'd0, 6'd9, 5'(8 + i));
            step();
        end
        check("full_flag", iq_full, 1);
        check("full_count", dut.count, 8);
        dispatch(4'd7, 32'h16, 1'b1, 6'd0, 32'h16, 1'b1, 6'd0, 32'd0, 6'd10, 5'd16);
        wb0_valid = 1'b1; wb0_ptag = 6'd20; wb0_value = 32'h20;
        step();
        wb0_valid = 1'b0;
        check("full_no_accept", dut.count, 8);
        check("full_flag_hold", iq_full, 1);
        step();
        check("full_issue_en", alu_issue_en, 1);
        check("full_issue_rob", alu_issue_queue_rob_ptr, 8);
        check("full_issue_rs1", alu_issue_queue_rs1_value, 32'h20);
        check("full_issue_no_accept", dut.count, 7);
        check("full_flag_clear", iq_full, 0);
        step(); idle();
        check("full_accept_count", dut.count, 8);
        check("full_accept_idx7", dut.q[7].rob_ptr, 16);
        check("full_accept_vld7", dut.q[7].valid, 1);
        check("full_shift_idx0", dut.q[0].rob_ptr, 9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("full_flush_en", alu_issue_en, 0);
        check("full_flush_count", dut.count, 0);

        // Flush with five pending, one selected
        for (int i = 0; i < 4; i++) begin
            dispatch(4'd8, 32'd0, 1'b0, 6'(40 + i), 32'd0, 1'b1, 6'd0, 32'd0, 6'd11, 5'(20 + i));
            step();
        end
        dispatch(4'd8, 32'd0, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2, 6'd12, 5'd24);
        step(); idle();
        check("flush5_count", dut.count, 5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_en", alu_issue_en, 0);
        check("flush_count", dut.count, 0);
        check("flush_full", iq_full, 0);
        step();
        check("flush_after_en", alu_issue_en, 0);

        // Asynchronous reset mid-run
        dispatch(4'd3, 32'h77, 1'b1, 6'd0, 32'h99, 1'b1, 6'd0, 32'd0, 6'd13, 5'd25);
        step(); idle();
        step();
        check("prerst_en", alu_issue_en, 1);
        check("prerst_imm", alu_issue_queue_imm, 32'h77);
        #2;
        rst = 1'b1;
        #1;
        check("rst_en", alu_issue_en, 0);
        check("rst_imm", alu_issue_queue_imm, 0);
        check("rst_rs1", alu_issue_queue_rs1_value, 0);
        check("rst_op", alu_issue_queue_op, 0);
        check("rst_rob", alu_issue_queue_rob_ptr, 0);
        check("rst_pc", alu_issue_queue_pc, 0);
        check("rst_count", dut.count, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("postrst_en", alu_issue_en, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
